// File: rtl/satcom_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | satcom_pkg                                                                 |
// | Shared types and constants for the satcom UART byte path.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package satcom_pkg;

    localparam int BYTE_W           = 8;
    localparam int CLK_DIVISOR      = 2604;
    // wrn must span two clk16x periods so txmit samples it reliably
    localparam int WRN_HOLD_DEFAULT = 2 * CLK_DIVISOR;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        STROBE   = 3'd2,
        WAIT_ACK = 3'd3,
        WAIT_RDY = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo                                                                  |
// | Single-clock FIFO with occupancy count and same-cycle push/pop.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            if (i_push && !i_pop)
                r_count <= r_count + (c_ADDR_W+1)'(1);
            else if (!i_push && i_pop)
                r_count <= r_count - (c_ADDR_W+1)'(1);
        end
    end

    // Storage carries no reset; pointers alone define validity
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (c_ADDR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_packer                                                             |
// | Packs serial bits LSB-first into bytes and writes them to txmit.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_packer
    import satcom_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WRN_HOLD    = WRN_HOLD_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    input  logic                   flush,
    input  logic                   tbre,
    output logic [BYTE_W-1:0]      tdin,
    output logic                   wrn,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
);

    localparam int c_HOLD_W = $clog2(WRN_HOLD + 1);

    logic [2:0]          r_bit_cnt;
    logic [BYTE_W-1:0]   r_sr;
    logic [BYTE_W-1:0]   w_sr_ins;
    logic [2:0]          w_fill;
    logic                w_accept;
    logic                w_push;
    logic [BYTE_W-1:0]   w_push_data;
    logic                w_pop;
    logic [BYTE_W-1:0]   w_rdata;
    logic                w_full;
    logic                w_empty;
    logic [SYNC_STAGES-1:0] r_tbre_sync;
    logic                w_tbre_s;
    tx_state_t           r_state;
    tx_state_t           w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_wrn;
    logic [BYTE_W-1:0]   r_tdin;

    assign w_accept = bit_valid && !w_full;

    always_comb begin
        w_sr_ins            = r_sr;
        w_sr_ins[r_bit_cnt] = bit_in;
    end

    // Bits above the fill level stay zero, so a flushed byte is already padded
    assign w_fill      = w_accept ? (r_bit_cnt + 3'd1) : r_bit_cnt;
    assign w_push_data = w_accept ? w_sr_ins : r_sr;
    assign w_push      = !w_full && ((w_accept && (r_bit_cnt == 3'd7)) ||
                                     (flush && (w_fill != 3'd0)));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_cnt <= '0;
            r_sr      <= '0;
        end else if (w_push) begin
            r_bit_cnt <= '0;
            r_sr      <= '0;
        end else if (w_accept) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_sr      <= w_sr_ins;
        end
    end

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) r_tbre_sync <= '0;
                else      r_tbre_sync <= tbre;
            end
        end else begin : g_sync_chain
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) r_tbre_sync <= '0;
                else      r_tbre_sync <= {r_tbre_sync[SYNC_STAGES-2:0], tbre};
            end
        end
    endgenerate

    assign w_tbre_s = r_tbre_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && w_tbre_s) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP:    w_state_nxt = STROBE;
            STROBE:   if (r_hold_cnt == '0) w_state_nxt = WAIT_ACK;
            WAIT_ACK: if (!w_tbre_s)        w_state_nxt = WAIT_RDY;
            WAIT_RDY: if (w_tbre_s)         w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // wrn is registered from the next state so the strobe is glitch-free
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_wrn      <= 1'b1;
            r_hold_cnt <= '0;
            r_tdin     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wrn   <= (w_state_nxt != STROBE);
            if (r_state == SETUP)
                r_hold_cnt <= c_HOLD_W'(WRN_HOLD - 1);
            else if ((r_state == STROBE) && (r_hold_cnt != '0))
                r_hold_cnt <= r_hold_cnt - c_HOLD_W'(1);
            if (w_pop)
                r_tdin <= w_rdata;
        end
    end

    assign bit_ready = !w_full;
    assign tdin      = r_tdin;
    assign wrn       = r_wrn;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_packer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_uart_tx_packer                                                          |
// | Self-checking bench with a txmit model and a bit-to-byte reference model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_tx_packer;

    localparam int DEPTH = 16;
    localparam int HOLD  = 64;
    localparam int SYNC  = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       flush = 1'b0;
    logic       txm_tbre = 1'b1;
    logic       tbre_gate = 1'b1;
    logic       tbre_jit = 1'b1;
    logic       tbre;
    logic       bit_ready, wrn, busy;
    logic [7:0] tdin;
    logic [4:0] fifo_count;
    logic       d_bit_ready, d_wrn, d_busy;
    logic [7:0] d_tdin;
    logic [4:0] d_fifo_count;

    assign tbre = txm_tbre & tbre_gate & tbre_jit;

    always #5 CLK = ~CLK;

    uart_tx_packer #(.DEPTH(DEPTH), .WRN_HOLD(HOLD), .SYNC_STAGES(SYNC)) dut (
        .CLK(CLK), .RST(RST), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .flush(flush), .tbre(tbre), .tdin(tdin),
        .wrn(wrn), .fifo_count(fifo_count), .busy(busy)
    );

    // Default-parameter instance: full-length strobe on the first byte only
    uart_tx_packer dut_def (
        .CLK(CLK), .RST(RST), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(d_bit_ready), .flush(1'b0), .tbre(1'b1), .tdin(d_tdin),
        .wrn(d_wrn), .fifo_count(d_fifo_count), .busy(d_busy)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] got_q[$];
    int         low_q[$];
    logic [7:0] exp_q[$];
    logic       bit_pend[$];
    int         checked = 0;
    int         low_cnt = 0;
    logic       in_low = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    int         tdin_glitch = 0;
    int         txm_busy = 0;
    int         d_low = 0;
    logic       d_in_low = 1'b0;
    int         d_strobes = 0;
    int         d_len = 0;
    logic [7:0] d_byte = 8'h00;
    logic       jit_on = 1'b0;

    // txmit model: latches tdin on each completed strobe, then is busy a while
    always @(negedge CLK) begin
        if (txm_busy > 0) begin
            txm_busy--;
            if (txm_busy == 0) txm_tbre = 1'b1;
        end
        if (!RST) begin
            in_low  = 1'b0;
            low_cnt = 0;
        end else if (!wrn) begin
            if (!in_low) begin
                in_low   = 1'b1;
                low_cnt  = 0;
                cur_byte = tdin;
            end
            low_cnt++;
            if (tdin !== cur_byte) tdin_glitch++;
        end else if (in_low) begin
            in_low = 1'b0;
            got_q.push_back(cur_byte);
            low_q.push_back(low_cnt);
            txm_busy = $urandom_range(3, 12);
            txm_tbre = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            if (!d_wrn) begin
                if (!d_in_low) begin
                    d_in_low = 1'b1;
                    d_low    = 0;
                    d_byte   = d_tdin;
                end
                d_low++;
            end else if (d_in_low) begin
                d_in_low = 1'b0;
                d_strobes++;
                d_len = d_low;
            end
        end
    end

    initial begin
        wait (jit_on);
        while (jit_on) begin
            #(real'($urandom_range(3000, 41000)) / 1000.0);
            tbre_jit = ~tbre_jit;
        end
        tbre_jit = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Reference: k-th bit of a byte carries weight 2**k; flush pads with zeros
    function automatic logic [7:0] pack_pending();
        int v = 0;
        for (int k = 0; k < bit_pend.size(); k++)
            if (bit_pend[k]) v += (1 << k);
        return 8'(v);
    endfunction

    task automatic model_bit(input logic b);
        bit_pend.push_back(b);
        if (bit_pend.size() == 8) begin
            exp_q.push_back(pack_pending());
            bit_pend.delete();
        end
    endtask

    task automatic send_bit(input logic b);
        int guard = 0;
        while (!bit_ready && guard < 20000) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 20000) timeout_fail("bit_ready_wait");
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge CLK);
        bit_valid = 1'b0;
        model_bit(b);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int k = 0; k < 8; k++) send_bit(v[k]);
    endtask

    task automatic do_flush();
        int guard = 0;
        while (!bit_ready && guard < 20000) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 20000) timeout_fail("flush_wait");
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        if (bit_pend.size() > 0) begin
            exp_q.push_back(pack_pending());
            bit_pend.delete();
        end
    endtask

    task automatic wait_drain(input string tag);
        int guard = 0;
        while ((got_q.size() < exp_q.size() || busy || fifo_count != 0) && guard < 20000) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 20000) timeout_fail(tag);
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = checked; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        checked = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] r;
        int         guard;
        int         nstrobe;

        repeat (3) @(negedge CLK);
        check("rst_wrn", wrn, 1'b1);
        check("rst_tdin", tdin, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 5'd0);
        check("rst_ready", bit_ready, 1'b1);
        RST = 1'b1;
        repeat (4) @(negedge CLK);

        pat = 8'b0100_1101;
        for (int k = 0; k < 8; k++) send_bit(pat[k]);
        check("t1_count", fifo_count, 5'd1);
        wait_drain("t1_drain");
        compare_all("t1");
        check("t1_byte", got_q[got_q.size()-1], 8'h4D);
        guard = 0;
        while (d_strobes < 1 && guard < 8000) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 8000) timeout_fail("t1_default_strobe");
        check("t1_def_byte", d_byte, 8'h4D);
        check("t1_def_hold", d_len, 5208);

        tbre_gate = 1'b0;
        repeat (4) @(negedge CLK);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        do_flush();
        check("t2_flush_count", fifo_count, 5'd1);
        do_flush();
        check("t2_reflush_count", fifo_count, 5'd1);
        tbre_gate = 1'b1;
        wait_drain("t2_drain");
        compare_all("t2");
        check("t2_byte", got_q[got_q.size()-1], 8'h07);

        tbre_gate = 1'b0;
        repeat (4) @(negedge CLK);
        for (int i = 0; i < 16; i++) send_byte(8'($urandom));
        check("t3_full_count", fifo_count, 5'd16);
        check("t3_full_ready", bit_ready, 1'b0);
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        repeat (10) @(negedge CLK);
        bit_valid = 1'b0;
        check("t3_held_count", fifo_count, 5'd16);
        check("t3_held_ready", bit_ready, 1'b0);
        tbre_gate = 1'b1;
        wait_drain("t3_drain");
        compare_all("t3");

        tbre_gate = 1'b0;
        repeat (4) @(negedge CLK);
        send_byte(8'($urandom));
        r = 8'($urandom);
        for (int k = 0; k < 7; k++) send_bit(r[k]);
        tbre_gate = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        send_bit(r[7]);
        check("t4_count", fifo_count, 5'd1);
        check("t4_busy", busy, 1'b1);
        wait_drain("t4_drain");
        compare_all("t4");

        tbre_gate = 1'b0;
        repeat (4) @(negedge CLK);
        send_byte(8'h3C);
        send_byte(8'hC3);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        tbre_gate = 1'b1;
        guard = 0;
        while (wrn && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 1000) timeout_fail("t5_strobe_wait");
        repeat (10) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("t5_wrn", wrn, 1'b1);
        check("t5_count", fifo_count, 5'd0);
        check("t5_busy", busy, 1'b0);
        check("t5_ready", bit_ready, 1'b1);
        while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        bit_pend.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        send_byte(8'hA5);
        wait_drain("t5_drain");
        compare_all("t5");
        check("t5_byte", got_q[got_q.size()-1], 8'hA5);

        jit_on = 1'b1;
        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(0, 9) == 0) do_flush();
            else send_bit(1'($urandom_range(0, 1)));
        end
        do_flush();
        jit_on = 1'b0;
        repeat (100) @(negedge CLK);
        wait_drain("t6_drain");
        compare_all("t6");
        nstrobe = got_q.size();
        repeat (200) @(negedge CLK);
        check("t6_no_spurious", got_q.size(), nstrobe);

        check("tdin_stable", tdin_glitch, 0);
        for (int i = 0; i < low_q.size(); i++)
            check($sformatf("hold%0d", i), low_q[i], HOLD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
